wallace_tree_mult: RTL and testbench

- Unsigned 32x32 multiplier using a Wallace-tree reduction.
- AND-array partial products are compressed to two rows by carry-save adders, then summed by a final 64-bit carry-propagate adder.
- Operand capture and result output are registered, giving a fixed-latency pipelined block for datapath use.

---
 rtl/wallace_tree_mult.sv | 103 ++++++++++
 tb/tb_wallace_tree_mult.sv | 129 ++++++++++++
 2 files changed

// File: rtl/wallace_tree_mult.sv
// Unsigned 32x32 pipelined multiplier.
// Operands are registered, an AND-array of partial products is reduced
// Wallace-style by layers of 3:2 carry-save compressors down to two rows,
// and a 64-bit carry-propagate adder feeds the registered product.
module wallace_tree_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] s,
  output logic        cout
);

  // 32 rows compress 32->22->15->10->7->5->4->3->2, so eight layers suffice.
  localparam int unsigned LAYERS = 8;

  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [31:0][63:0] pp;
  logic [31:0][63:0] cur;
  logic [31:0][63:0] nxt;
  logic [63:0]       row_sum;
  logic [63:0]       row_carry;
  logic [64:0]       cpa;

  // Operand capture; reset discards whatever was presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Partial-product rows: row i is a_r gated by b_r[i], weighted by 2^i.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      pp[5'(i)] = b_r[5'(i)] ? (64'(a_r) << i) : '0;
    end
  end

  // Wallace reduction. Each layer turns every complete group of three rows
  // into a sum row and a shifted carry row (full adders per column); rows
  // left over from the grouping pass straight through. Output rows are
  // packed as [sum0, carry0, sum1, carry1, ..., leftovers].
  always_comb begin : reduce
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
    int unsigned n;
    int unsigned g;
    x   = '0;
    y   = '0;
    z   = '0;
    n   = 32;
    g   = 0;
    cur = pp;
    nxt = '0;
    for (int unsigned layer = 0; layer < LAYERS; layer++) begin
      g   = n / 3;
      nxt = '0;
      for (int unsigned j = 0; j < 32; j++) begin
        if (j < 2 * g) begin
          x = cur[5'(3 * (j / 2))];
          y = cur[5'(3 * (j / 2) + 1)];
          z = cur[5'(3 * (j / 2) + 2)];
          if (j % 2 == 0) begin
            nxt[5'(j)] = x ^ y ^ z;
          end else begin
            // Carry out of column 63 is dropped: the product fits in 64 bits.
            nxt[5'(j)] = ((x & y) | (x & z) | (y & z)) << 1;
          end
        end else if (j < n - g) begin
          nxt[5'(j)] = cur[5'(j + g)];
        end
      end
      cur = nxt;
      n   = n - g;
    end
    row_sum   = cur[0];
    row_carry = cur[1];
  end

  // Final carry-propagate adder over the two remaining rows.
  always_comb begin
    cpa = {1'b0, row_sum} + {1'b0, row_carry};
  end

  // Result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= cpa[63:0];
      cout <= cpa[64];
    end
  end

endmodule

// File: tb/tb_wallace_tree_mult.sv
// Self-checking bench for wallace_tree_mult: directed cases plus randomized
// operands checked against a plain 64-bit product with a two-edge delay.
module tb_wallace_tree_mult;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] s;
  logic        cout;

  int total = 0;
  int bad = 0;

  // Reference state: reset and product presented at the previous edge.
  logic        prev_rst = 1'b1;
  logic [63:0] prev_prod = '0;
  bit          known = 1'b0;

  always #5 clk = ~clk;

  wallace_tree_mult dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .s     (s),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one input set for one edge, then compare outputs after that edge.
  // Output after edge k is zero if reset was high at edge k or k-1, otherwise
  // the product of the operands presented at edge k-1.
  task automatic cycle(input logic r, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    @(negedge clk);
    reset = r;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    exp = (r || prev_rst) ? 64'd0 : prev_prod;
    if (r) known = 1'b1;
    if (known) begin
      check("s", s, exp);
      check("cout", {63'd0, cout}, 64'd0);
    end
    prev_rst  = r;
    prev_prod = 64'(x) * 64'(y);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset for two cycles, then 3*3 held.
    cycle(1'b1, 32'd0, 32'd0);
    check("reset_s", s, 64'd0);
    cycle(1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd3, 32'd3);
    check("hold9", s, 64'd9);

    // Maximum operands.
    cycle(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycle(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("max", s, 64'hFFFFFFFE00000001);
    check("max_cout", {63'd0, cout}, 64'd0);

    // Carry into bit 32, then zero operand.
    cycle(1'b0, 32'h80000000, 32'd2);
    cycle(1'b0, 32'd0, 32'hDEADBEEF);
    check("bit32", s, 64'h0000000100000000);
    cycle(1'b0, 32'd0, 32'hDEADBEEF);
    check("zero_a", s, 64'd0);

    // Back-to-back stream.
    cycle(1'b0, 32'd7, 32'd19);
    cycle(1'b0, 32'd12345, 32'd6789);
    check("b2b_0", s, 64'd133);
    cycle(1'b0, 32'hFFFF0000, 32'h0000FFFF);
    check("b2b_1", s, 64'd83810205);
    cycle(1'b0, 32'd5, 32'd0);
    check("b2b_2", s, 64'h0000FFFE00010000);
    cycle(1'b0, 32'd0, 32'd0);
    check("zero_b", s, 64'd0);

    // Reset while 3*3 is in flight.
    cycle(1'b0, 32'd3, 32'd3);
    cycle(1'b1, 32'd5, 32'd5);
    check("midrst_s", s, 64'd0);
    check("midrst_cout", {63'd0, cout}, 64'd0);
    cycle(1'b0, 32'd6, 32'd7);
    check("release0", s, 64'd0);
    cycle(1'b0, 32'd0, 32'd0);
    check("release42", s, 64'd42);

    // Single operand bit at each position.
    for (int i = 0; i < 32; i++) begin
      ra = 32'd1 << i;
      cycle(1'b0, ra, $urandom);
      rb = 32'd1 << i;
      cycle(1'b0, $urandom, rb);
      cycle(1'b0, ra, 32'hFFFFFFFF);
    end

    // Random operands with occasional reset pulses.
    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) rb = ra;
      cycle($urandom_range(0, 99) == 0, ra, rb);
    end
    cycle(1'b0, 32'd0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
